// File: rtl/shift_reg.sv
// Bidirectional serial-in, parallel-out shift register with shift enable.
// Contents are cleared asynchronously by an active-low reset.
module shift_reg #(
   parameter int MSB = 8
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           d,
   input  logic           en,
   input  logic           dir,
   output logic [MSB-1:0] out
);

   // dir=0 shifts toward the top bit (d enters bit 0); dir=1 shifts toward bit 0 (d enters the top bit)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out <= '0;
      end else if (en) begin
         if (dir) begin
            out <= {d, out[MSB-1:1]};
         end else begin
            out <= {out[MSB-2:0], d};
         end
      end
   end

endmodule

// File: tb/tb_shift_reg.sv
// Directed self-checking bench for shift_reg at MSB=4.
// Inputs change on the falling edge; outputs are checked 1ns after the rising edge.
module tb_shift_reg;

   logic       clk;
   logic       rstn;
   logic       d;
   logic       en;
   logic       dir;
   logic [3:0] out;

   int unsigned tests_run;
   int unsigned tests_failed;

   shift_reg #(.MSB(4)) dut (
      .clk  (clk),
      .rstn (rstn),
      .d    (d),
      .en   (en),
      .dir  (dir),
      .out  (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] exp);
      tests_run++;
      assert (out === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %b expected %b", tag, out, exp);
      end
   endtask

   task automatic step(input logic e, input logic dr, input logic dd,
                       input logic [3:0] exp, input string tag);
      @(negedge clk);
      en  = e;
      dir = dr;
      d   = dd;
      @(posedge clk);
      #1;
      check(tag, exp);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rstn = 1'b0;
      en   = 1'b1;
      dir  = 1'b0;
      d    = 1'b1;

      // reset held with clock running and shifting requested
      @(posedge clk); #1;
      check("reset_edge1", 4'b0000);
      @(posedge clk); #1;
      check("reset_edge2", 4'b0000);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("reset_release_no_edge", 4'b0000);

      // left fill: first edge after release performs the first shift
      @(posedge clk); #1;
      check("fill_1", 4'b0001);
      step(1'b1, 1'b0, 1'b1, 4'b0011, "fill_2");
      step(1'b1, 1'b0, 1'b1, 4'b0111, "fill_3");
      step(1'b1, 1'b0, 1'b1, 4'b1111, "fill_4");

      // right drain, direction switched with no bubble
      step(1'b1, 1'b1, 1'b0, 4'b0111, "drain_1");
      step(1'b1, 1'b1, 1'b0, 4'b0011, "drain_2");
      step(1'b1, 1'b1, 1'b0, 4'b0001, "drain_3");
      step(1'b1, 1'b1, 1'b0, 4'b0000, "drain_4");

      // alternating left shift
      step(1'b1, 1'b0, 1'b1, 4'b0001, "alt_1");
      step(1'b1, 1'b0, 1'b0, 4'b0010, "alt_2");
      step(1'b1, 1'b0, 1'b1, 4'b0101, "alt_3");
      step(1'b1, 1'b0, 1'b0, 4'b1010, "alt_4");

      // hold with d and dir toggling
      step(1'b0, 1'b1, 1'b1, 4'b1010, "hold_1");
      step(1'b0, 1'b0, 1'b0, 4'b1010, "hold_2");
      step(1'b0, 1'b1, 1'b1, 4'b1010, "hold_3");

      // enable pulsed between edges must not shift
      @(negedge clk);
      en = 1'b1;
      #2;
      en = 1'b0;
      @(posedge clk); #1;
      check("hold_mid_cycle_en", 4'b1010);

      // walk to 0111: 1010 -> 0101 -> 1011 -> 0111
      step(1'b1, 1'b0, 1'b1, 4'b0101, "walk_1");
      step(1'b1, 1'b0, 1'b1, 4'b1011, "walk_2");
      step(1'b1, 1'b0, 1'b1, 4'b0111, "walk_3");

      // asynchronous reset between edges
      #2;
      rstn = 1'b0;
      #1;
      check("async_reset_immediate", 4'b0000);
      @(posedge clk); #1;
      check("async_reset_held", 4'b0000);
      @(negedge clk);
      rstn = 1'b1;
      en   = 1'b1;
      dir  = 1'b0;
      d    = 1'b1;
      @(posedge clk); #1;
      check("after_async_reset", 4'b0001);

      // right shift of a single bit from the top after a direction change
      step(1'b1, 1'b1, 1'b1, 4'b1000, "right_in_1");
      step(1'b1, 1'b1, 1'b0, 4'b0100, "right_in_2");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
